aes_iter_enc: RTL and testbench

//  Iterative FIPS-197 AES encryption core: one round per clock, sharing a single sub_byte/shift_row/mix_col datapath.

---
 rtl/aes_iter_enc.sv | 214 +++++++++++++++++++++
 tb/tb_aes_iter_enc.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_enc.sv
// Iterative FIPS-197 AES encryptor. The key schedule is expanded one word per cycle into
// a register file. The cipher then runs one round per cycle through a shared round datapath.
module aes_iter_enc #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                key_load,
    output logic                key_ready,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                busy,
    output logic [2:0]          dbg_state
);
    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_iter_enc: KEY_BITS must be 128, 192 or 256");
    end

    // FIPS byte 0 is the most significant byte of every 128-bit / key vector.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [2:0] {S_IDLE, S_KEXP, S_READY, S_RUN, S_DONE} state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] top;
        top = 11'h7ff - {b, 3'b000};
        return SBOX[top -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // SubBytes + ShiftRows + (optional) MixColumns; byte k sits at row k%4, column k/4.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sbox(s[127 - 8*(4*((c+r)%4) + r) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            if (last) begin
                o[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
            end
        end
        return o;
    endfunction

    state_t       state_q, state_d;
    logic [31:0]  w_q [NW];
    logic [5:0]   i_q;
    logic [2:0]   k_q;
    logic [7:0]   rcon_q;
    logic [3:0]   r_q;
    logic [127:0] st_q, out_data_q;
    logic         kexp_load, kexp_step, accept;

    // Handshakes: a word moves on a rising edge where valid && ready. The source holds
    // in_data/in_valid until in_ready. out_data/out_valid stay frozen until out_ready.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        kexp_load = 1'b0;
        kexp_step = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (key_load) begin
                    kexp_load = 1'b1;
                    state_d   = S_KEXP;
                end
            end
            S_KEXP: begin
                if (key_load) begin
                    kexp_load = 1'b1;
                end else begin
                    kexp_step = 1'b1;
                    if (i_q == 6'(NW - 1)) state_d = S_READY;
                end
            end
            S_READY: begin
                in_ready = !key_load;
                if (key_load) begin
                    kexp_load = 1'b1;
                    state_d   = S_KEXP;
                end else if (in_valid) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (r_q == 4'(NR)) state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_READY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [5:0]   rk_base;
    logic [127:0] rk, rk0, round_out;
    logic [31:0]  w_prev, w_back, kx_t, kx_word;

    always_comb begin
        rk      = '0;
        rk0     = '0;
        rk_base = {r_q, 2'b00};
        for (int j = 0; j < 4; j++) begin
            rk[127-32*j -: 32]  = w_q[rk_base + 6'(j)];
            rk0[127-32*j -: 32] = w_q[j];
        end
        round_out = aes_round(st_q, r_q == 4'(NR)) ^ rk;
        w_prev    = w_q[i_q - 6'd1];
        w_back    = w_q[i_q - 6'(NK)];
        kx_t      = w_prev;
        if (k_q == 3'd0) begin
            kx_t = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon_q, 24'h000000};
        end else if (NK == 8 && k_q == 3'd4) begin
            kx_t = sub_word(w_prev);
        end
        kx_word = w_back ^ kx_t;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // k_q tracks i mod NK so the schedule never needs a divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_q        <= '0;
            k_q        <= '0;
            rcon_q     <= '0;
            r_q        <= '0;
            st_q       <= '0;
            out_data_q <= '0;
        end else begin
            if (kexp_load) begin
                i_q    <= 6'(NK);
                k_q    <= '0;
                rcon_q <= 8'h01;
            end else if (kexp_step) begin
                i_q <= i_q + 6'd1;
                k_q <= (k_q == 3'(NK - 1)) ? 3'd0 : k_q + 3'd1;
                if (k_q == 3'd0) rcon_q <= xtime(rcon_q);
            end
            if (accept) begin
                st_q <= in_data ^ rk0;
                r_q  <= 4'd1;
            end else if (state_q == S_RUN) begin
                if (r_q == 4'(NR)) begin
                    out_data_q <= round_out;
                    r_q        <= '0;
                end else begin
                    st_q <= round_out;
                    r_q  <= r_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (kexp_load) begin
                for (int j = 0; j < NK; j++) w_q[j] <= key_in[KEY_BITS-1-32*j -: 32];
            end else if (kexp_step) begin
                w_q[i_q] <= kx_word;
            end
        end
    end

    assign key_ready = (state_q == S_READY) || (state_q == S_RUN) || (state_q == S_DONE);
    assign out_valid = (state_q == S_DONE);
    assign out_data  = out_data_q;
    assign busy      = (state_q == S_KEXP) || (state_q == S_RUN);
    assign dbg_state = state_q;
endmodule

// File: tb/tb_aes_iter_enc.sv
// Directed FIPS-197 vectors for aes_iter_enc at 128/192/256-bit keys, with a
// scoreboard that checks every ciphertext the cores hand out.
module tb_aes_iter_enc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PTB = 128'h00112233445566778899aabbccddeeff;

    logic         rst;
    logic [127:0] in_data;
    logic         out_ready;
    logic [2:0]   key_load_v, in_valid_v;
    logic [2:0]   key_ready_v, in_ready_v, out_valid_v, busy_v;
    logic [127:0] out_data_v [3];
    logic [2:0]   dbg_v [3];
    logic [127:0] key128;
    logic [191:0] key192;
    logic [255:0] key256;

    logic [129:0] exp_q [$];
    int n_checks = 0;
    int n_fail = 0;

    aes_iter_enc #(.KEY_BITS(128)) u_aes128 (
        .clk(clk), .rst(rst), .key_in(key128), .key_load(key_load_v[0]),
        .key_ready(key_ready_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_data(in_data), .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .out_data(out_data_v[0]), .busy(busy_v[0]), .dbg_state(dbg_v[0])
    );
    aes_iter_enc #(.KEY_BITS(192)) u_aes192 (
        .clk(clk), .rst(rst), .key_in(key192), .key_load(key_load_v[1]),
        .key_ready(key_ready_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_data(in_data), .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .out_data(out_data_v[1]), .busy(busy_v[1]), .dbg_state(dbg_v[1])
    );
    aes_iter_enc #(.KEY_BITS(256)) u_aes256 (
        .clk(clk), .rst(rst), .key_in(key256), .key_load(key_load_v[2]),
        .key_ready(key_ready_v[2]), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_data(in_data), .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .out_data(out_data_v[2]), .busy(busy_v[2]), .dbg_state(dbg_v[2])
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: pops one expected ciphertext per completed output transfer.
    always @(negedge clk) begin
        logic [129:0] e;
        if (!rst && out_ready) begin
            for (int d = 0; d < 3; d++) begin
                if (out_valid_v[d]) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_unexpected: dut %0d gave %h, nothing expected", d, out_data_v[d]);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_dut", 128'(d), 128'(e[129:128]));
                        check("sb_ciphertext", out_data_v[d], e[127:0]);
                    end
                end
            end
        end
    end

    // Called just after the load edge: checks KEXP entry and the cycles until key_ready.
    task automatic wait_key(input int d, input int lat, input string name);
        int n = 0;
        check({name, "_kexp_busy"}, 128'(busy_v[d]), 128'(1));
        check({name, "_kexp_key_ready"}, 128'(key_ready_v[d]), 128'(0));
        while (!key_ready_v[d] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_key_latency"}, 128'(n), 128'(lat));
    endtask

    task automatic load_key(input int d, input int lat, input string name);
        key_load_v[d] = 1'b1;
        @(posedge clk); #1;
        key_load_v[d] = 1'b0;
        wait_key(d, lat, name);
    endtask

    task automatic send_block(input int d, input logic [127:0] pt, input logic [127:0] ct,
                              input int lat, input bit kl_run, input string name);
        int n = 0;
        exp_q.push_back({2'(d), ct});
        in_data       = pt;
        in_valid_v[d] = 1'b1;
        while (!in_ready_v[d] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid_v[d] = 1'b0;
        if (kl_run) begin
            key128        = ~key128;
            key_load_v[d] = 1'b1;
        end
        n = 0;
        while (!out_valid_v[d] && n < 200) begin
            @(posedge clk); #1;
            key_load_v[d] = 1'b0;
            n++;
        end
        key_load_v[d] = 1'b0;
        check({name, "_latency"}, 128'(n), 128'(lat));
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_key_ready"}, 128'(key_ready_v[0]), 128'(0));
        check({name, "_out_valid"}, 128'(out_valid_v[0]), 128'(0));
        check({name, "_busy"}, 128'(busy_v[0]), 128'(0));
        check({name, "_in_ready"}, 128'(in_ready_v[0]), 128'(0));
    endtask

    initial begin
        int stall_bad;
        rst        = 1'b1;
        in_data    = '0;
        out_ready  = 1'b1;
        key_load_v = '0;
        in_valid_v = '0;
        key128     = '0;
        key192     = '0;
        key256     = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check("rst_key_ready", 128'(key_ready_v[d]), 128'(0));
            check("rst_out_valid", 128'(out_valid_v[d]), 128'(0));
            check("rst_busy", 128'(busy_v[d]), 128'(0));
            check("rst_in_ready", 128'(in_ready_v[d]), 128'(0));
            check("rst_out_data", out_data_v[d], 128'(0));
            check("rst_state", 128'(dbg_v[d]), 128'(0));
        end

        // T1: FIPS-197 appendix B
        key128 = KEY1;
        load_key(0, 40, "t1");
        send_block(0, PT1, CT1, 10, 1'b0, "t1");

        // T4: output backpressure, then a second block under a new key
        out_ready = 1'b0;
        send_block(0, PT1, CT1, 10, 1'b0, "t4a");
        stall_bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_data_v[0] !== CT1 || !out_valid_v[0] || in_ready_v[0]) stall_bad++;
        end
        check("t4_stall_hold", 128'(stall_bad), 128'(0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_in_ready_after_drain", 128'(in_ready_v[0]), 128'(1));
        check("t4_out_valid_drop", 128'(out_valid_v[0]), 128'(0));
        key128 = 128'h000102030405060708090a0b0c0d0e0f;
        load_key(0, 40, "t4b");
        send_block(0, PTB, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10, 1'b0, "t4b");

        // T5: key_load beats in_valid in READY; key_load during RUN is ignored
        key128        = KEY1;
        key_load_v[0] = 1'b1;
        in_valid_v[0] = 1'b1;
        in_data       = PT1;
        #1 check("t5_in_ready_low", 128'(in_ready_v[0]), 128'(0));
        @(posedge clk); #1;
        key_load_v[0] = 1'b0;
        in_valid_v[0] = 1'b0;
        wait_key(0, 40, "t5");
        send_block(0, PT1, CT1, 10, 1'b1, "t5_run_load");
        check("t5_key_ready_kept", 128'(key_ready_v[0]), 128'(1));

        // T6: reset mid-KEXP and mid-RUN, then a clean rerun of T1
        key128        = KEY1;
        key_load_v[0] = 1'b1;
        @(posedge clk); #1;
        key_load_v[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("t6_kexp_rst");
        load_key(0, 40, "t6");
        in_data       = PT1;
        in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        check("t6_run_busy", 128'(busy_v[0]), 128'(1));
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("t6_run_rst");
        check("t6_run_rst_out_data", out_data_v[0], 128'(0));
        repeat (12) @(posedge clk);
        #1 check("t6_block_discarded", 128'(out_valid_v[0]), 128'(0));
        load_key(0, 40, "t6_reload");
        send_block(0, PT1, CT1, 10, 1'b0, "t6_rerun");

        // T2 / T3: FIPS-197 appendix C.2 and C.3
        key192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
        load_key(1, 46, "t2");
        send_block(1, PTB, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 12, 1'b0, "t2");
        key256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        load_key(2, 52, "t3");
        send_block(2, PTB, 128'h8ea2b7ca516745bfeafc49904b496089, 14, 1'b0, "t3");

        repeat (3) @(posedge clk);
        #1 check("sb_drain", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end
endmodule
